// File: rtl/debounce_multi.sv
// ---------------------------------------------------------------------------
// debounce_multi
//   N-channel push-button / switch conditioner. Each channel runs its own
//   two-flop synchroniser and stability counter. It produces a debounced
//   level and one-cycle press/release strobes. Channels can optionally
//   produce hold-to-repeat strobes.
//
//   Optional feature macro: DEBOUNCE_MULTI_REPEAT_EN
//     defined   - per-channel hold counter and IDLE/DELAY/RATE repeat FSM built
//     undefined - btn_repeat tied to zero; REPEAT_* parameters ignored
//
// Parameters
//   NCH              number of channels (1..32)
//   DEBOUNCE_CYC     stable cycles needed to accept a new level (>= 2)
//   ACTIVE_LOW       per-channel mask; set bit inverts that raw input
//   REPEAT_DELAY_CYC hold time from press strobe to first repeat (>= 2)
//   REPEAT_RATE_CYC  interval between later repeat strobes (>= 2)
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   btn_in       raw asynchronous button inputs
//   btn_level    debounced level, 1 = pressed
//   btn_press    one-cycle strobe on accepted 0->1
//   btn_release  one-cycle strobe on accepted 1->0
//   btn_repeat   one-cycle hold-repeat strobe
//   any_press    registered OR of btn_press (one cycle behind it)
// ---------------------------------------------------------------------------
module debounce_multi #(
  parameter int unsigned    NCH              = 5,
  parameter int unsigned    DEBOUNCE_CYC     = 2_000_000,
  parameter logic [NCH-1:0] ACTIVE_LOW       = {NCH{1'b0}},
  parameter int unsigned    REPEAT_DELAY_CYC = 50_000_000,
  parameter int unsigned    REPEAT_RATE_CYC  = 10_000_000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] btn_in,
  output logic [NCH-1:0] btn_level,
  output logic [NCH-1:0] btn_press,
  output logic [NCH-1:0] btn_release,
  output logic [NCH-1:0] btn_repeat,
  output logic           any_press
);

  // Elaboration-time parameter sanity checks
  if (NCH < 1 || NCH > 32) begin : g_bad_nch
    $error("debounce_multi: NCH must be in 1..32");
  end
  if (DEBOUNCE_CYC < 2) begin : g_bad_deb
    $error("debounce_multi: DEBOUNCE_CYC must be >= 2");
  end
  if (REPEAT_DELAY_CYC < 2 || REPEAT_RATE_CYC < 2) begin : g_bad_rep
    $error("debounce_multi: REPEAT_DELAY_CYC and REPEAT_RATE_CYC must be >= 2");
  end
  if (ACTIVE_LOW === {NCH{1'bx}}) begin : g_bad_al
    $error("debounce_multi: ACTIVE_LOW must be a defined mask");
  end

  localparam int unsigned    CNT_W   = $clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  // -------------------------------------------------------------------------
  // Debounce datapath state
  // -------------------------------------------------------------------------
  logic [NCH-1:0]   s0_q,      s0_d;
  logic [NCH-1:0]   s1_q,      s1_d;
  logic [NCH-1:0]   level_q,   level_d;
  logic [NCH-1:0]   press_q,   press_d;
  logic [NCH-1:0]   release_q, release_d;
  logic             any_press_q, any_press_d;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];

  // Synchroniser, stability counters, level and press/release strobes
  always_comb begin
    s0_d        = btn_in ^ ACTIVE_LOW;
    s1_d        = s0_q;
    level_d     = level_q;
    press_d     = '0;
    release_d   = '0;
    any_press_d = |press_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      // Counter only runs while the synchronised input disagrees with the
      // accepted level; any agreement (glitch back) restarts it from zero.
      if (s1_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i]   = s1_q[i];
          press_d[i]   = s1_q[i];
          release_d[i] = ~s1_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q        <= '0;
      s1_q        <= '0;
      level_q     <= '0;
      press_q     <= '0;
      release_q   <= '0;
      any_press_q <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      any_press_q <= any_press_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign any_press   = any_press_q;

`ifdef DEBOUNCE_MULTI_REPEAT_EN
  // -------------------------------------------------------------------------
  // Hold-to-repeat: per-channel IDLE -> DELAY -> RATE state machine
  // -------------------------------------------------------------------------
  localparam int unsigned REP_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
                                    REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int unsigned HCNT_W  = $clog2(REP_MAX);
  localparam logic [HCNT_W-1:0] DELAY_MAX = HCNT_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [HCNT_W-1:0] RATE_MAX  = HCNT_W'(REPEAT_RATE_CYC - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_RATE  = 2'd2;

  logic [1:0]        rep_st_q [NCH];
  logic [1:0]        rep_st_d [NCH];
  logic [HCNT_W-1:0] hcnt_q   [NCH];
  logic [HCNT_W-1:0] hcnt_d   [NCH];
  logic [NCH-1:0]    repeat_q, repeat_d;

  // Next-state and repeat strobe; decisions use the next debounced level so
  // a release accepted this cycle suppresses a coincident repeat.
  always_comb begin
    repeat_d = '0;
    for (int i = 0; i < NCH; i++) begin
      rep_st_d[i] = rep_st_q[i];
      hcnt_d[i]   = hcnt_q[i];
      if (!level_d[i]) begin
        rep_st_d[i] = ST_IDLE;
        hcnt_d[i]   = '0;
      end else if (press_d[i]) begin
        rep_st_d[i] = ST_DELAY;
        hcnt_d[i]   = '0;
      end else begin
        case (rep_st_q[i])
          ST_DELAY: begin
            if (hcnt_q[i] == DELAY_MAX) begin
              repeat_d[i] = 1'b1;
              hcnt_d[i]   = '0;
              rep_st_d[i] = ST_RATE;
            end else begin
              hcnt_d[i] = hcnt_q[i] + HCNT_W'(1);
            end
          end
          ST_RATE: begin
            if (hcnt_q[i] == RATE_MAX) begin
              repeat_d[i] = 1'b1;
              hcnt_d[i]   = '0;
            end else begin
              hcnt_d[i] = hcnt_q[i] + HCNT_W'(1);
            end
          end
          default: begin
            rep_st_d[i] = ST_IDLE;
            hcnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      repeat_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        rep_st_q[i] <= ST_IDLE;
        hcnt_q[i]   <= '0;
      end
    end else begin
      repeat_q <= repeat_d;
      for (int i = 0; i < NCH; i++) begin
        rep_st_q[i] <= rep_st_d[i];
        hcnt_q[i]   <= hcnt_d[i];
      end
    end
  end

  assign btn_repeat = repeat_q;
`else
  // Repeat feature not built
  assign btn_repeat = {NCH{1'b0}};
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// ---------------------------------------------------------------------------
// tb_debounce_multi
//   Scoreboard bench for debounce_multi (NCH=3, DEBOUNCE_CYC=4,
//   REPEAT_DELAY_CYC=10, REPEAT_RATE_CYC=3, ACTIVE_LOW=3'b100). A reference
//   model pushes the expected outputs for every clock edge into a queue; a
//   monitor pops and compares on the falling edge. Repeat expectations follow
//   DEBOUNCE_MULTI_REPEAT_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_debounce_multi;

  localparam int NCH   = 3;
  localparam int DCYC  = 4;
  localparam int RDLY  = 10;
  localparam int RRATE = 3;
  localparam logic [NCH-1:0] AL = 3'b100;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] btn_in;
  logic [NCH-1:0] btn_level, btn_press, btn_release, btn_repeat;
  logic           any_press;

  always #5 clk = ~clk;

  debounce_multi #(
    .NCH             (NCH),
    .DEBOUNCE_CYC    (DCYC),
    .ACTIVE_LOW      (AL),
    .REPEAT_DELAY_CYC(RDLY),
    .REPEAT_RATE_CYC (RRATE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat),
    .any_press  (any_press)
  );

  typedef struct packed {
    logic [NCH-1:0] lvl;
    logic [NCH-1:0] prs;
    logic [NCH-1:0] rls;
    logic [NCH-1:0] rpt;
    logic           anyp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // -------------------------------------------------------------------------
  // Reference model. Rule: the level flips when the last DCYC synchronised
  // samples all disagree with it; the synchronised sample after an edge is
  // the raw value seen one edge earlier (zero within two edges of reset).
  // Repeats fire at RDLY + k*RRATE edges after the press edge while held.
  // -------------------------------------------------------------------------
  logic [NCH-1:0] m_lvl        = '0;
  logic [NCH-1:0] m_raw_prev   = '0;
  logic [NCH-1:0] m_press_prev = '0;
  logic           m_rst_prev   = 1'b1;
  logic [NCH-1:0] m_hist[$];
  int             m_edge       = 0;
  int             m_hold_start[NCH];

  initial begin
    for (int k = 0; k < DCYC; k++) m_hist.push_back('0);
    for (int c = 0; c < NCH; c++) m_hold_start[c] = 0;
  end

  always @(posedge clk) begin
    exp_t           e;
    logic [NCH-1:0] raw_now, s1_now;
    bit             all_diff;
    int             t;
    e       = '0;
    raw_now = btn_in ^ AL;
    if (rst) begin
      m_lvl  = '0;
      s1_now = '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        all_diff = 1'b1;
        for (int k = 1; k <= DCYC; k++)
          if (m_hist[m_hist.size() - k][c] == m_lvl[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_lvl[c] = ~m_lvl[c];
          if (m_lvl[c]) begin
            e.prs[c]        = 1'b1;
            m_hold_start[c] = m_edge;
          end else begin
            e.rls[c] = 1'b1;
          end
        end
`ifdef DEBOUNCE_MULTI_REPEAT_EN
        else if (m_lvl[c]) begin
          t = m_edge - m_hold_start[c];
          if (t >= RDLY && ((t - RDLY) % RRATE) == 0) e.rpt[c] = 1'b1;
        end
`endif
      end
      e.anyp = |m_press_prev;
      s1_now = m_rst_prev ? '0 : m_raw_prev;
    end
    e.lvl = m_lvl;
    m_hist.push_back(s1_now);
    if (m_hist.size() > DCYC) void'(m_hist.pop_front());
    m_raw_prev   = raw_now;
    m_rst_prev   = rst;
    m_press_prev = e.prs;
    m_edge++;
    exp_q.push_back(e);
  end

  // -------------------------------------------------------------------------
  // Monitor: compares DUT outputs against the oldest expectation
  // -------------------------------------------------------------------------
  task automatic check(input string name, input logic [NCH-1:0] act,
                       input logic [NCH-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, expv);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("btn_level",   btn_level,   e.lvl);
      check("btn_press",   btn_press,   e.prs);
      check("btn_release", btn_release, e.rls);
      check("btn_repeat",  btn_repeat,  e.rpt);
      check("any_press",   {{(NCH-1){1'b0}}, any_press}, {{(NCH-1){1'b0}}, e.anyp});
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus (driven on falling edges)
  // -------------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int hold[NCH];
    int lens[7];
    lens = '{1, 2, 3, 5, 8, 20, 40};
    rst    = 1'b1;
    btn_in = 3'b100;               // ch2 is active-low: raw 1 means released
    idle(3);
    rst = 1'b0;
    idle(5);

    // Clean press and long hold on ch0, then release
    btn_in[0] = 1'b1; idle(30);
    btn_in[0] = 1'b0; idle(10);

    // Bounce on ch1, then settle high
    for (int k = 0; k < 4; k++) begin
      btn_in[1] = ((k % 2) == 0);
      idle(2);
    end
    btn_in[1] = 1'b1; idle(12);
    btn_in[1] = 1'b0; idle(10);

    // Active-low channel: press by driving low, release by driving high
    btn_in[2] = 1'b0; idle(10);
    btn_in[2] = 1'b1; idle(10);

    // Reset in the middle of a count on ch0, input held through it
    btn_in[0] = 1'b1; idle(4);
    rst = 1'b1; idle(1);
    rst = 1'b0; idle(12);
    btn_in[0] = 1'b0; idle(10);

    // Simultaneous press on ch0 and ch1
    btn_in[1:0] = 2'b11; idle(25);
    btn_in[1:0] = 2'b00; idle(10);

    // Randomised phase: random levels with random hold lengths, rare resets
    for (int c = 0; c < NCH; c++) hold[c] = 1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int c = 0; c < NCH; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          btn_in[c] = 1'($urandom_range(0, 1));
          hold[c]   = lens[$urandom_range(0, 6)];
        end
      end
      rst = ($urandom_range(0, 399) == 0);
      idle(1);
    end
    rst = 1'b0;
    idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
